// File: rtl/sm_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : sm_muldiv_if
// Description : Bus between the schoolMIPS control unit and the iterative
//               multiply/divide unit.
//               master (control unit) drives start/op/srcA/srcB/flush and
//               the MTHI/MTLO writes (wrHi/wrLo/wrData); slave (sm_muldiv)
//               returns busy/done and the hi/lo result registers.
// Revision    : 1.0 - initial release
// ============================================================================
interface sm_muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             flush;
    logic             wrHi;
    logic             wrLo;
    logic [WIDTH-1:0] wrData;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, srcA, srcB, flush, wrHi, wrLo, wrData,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, srcA, srcB, flush, wrHi, wrLo, wrData,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/sm_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : sm_muldiv
// Description : Iterative multiply/divide unit with HI/LO registers.
//               MULTU/MULT use shift-add, DIVU/DIV use restoring
//               shift-subtract, one iteration per cycle for WIDTH cycles,
//               followed by one sign-correction/write-back cycle.
// Ports       : clk, rst (async, active-high)
//               bus (sm_muldiv_if.slave):
//                 start, op[1:0] (00 MULTU, 01 MULT, 10 DIVU, 11 DIV),
//                 srcA, srcB, flush, wrHi, wrLo, wrData  -> inputs
//                 busy, done, hi, lo                     -> outputs
// Revision    : 1.0 - initial release
// ============================================================================
module sm_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    sm_muldiv_if.slave    bus
);
    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;

    // Captured operation context
    logic               r_is_div;
    logic               r_neg_res;   // product sign / quotient sign
    logic               r_neg_rem;   // remainder follows dividend sign
    logic               r_b_zero;
    logic [WIDTH-1:0]   r_b_mag;
    logic [WIDTH-1:0]   r_a_raw;

    // Shared accumulator: product for multiply, {remainder, quotient} for divide
    logic [2*WIDTH-1:0] r_acc;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    // ------------------------------------------------------------------
    // Operand conditioning at start
    // ------------------------------------------------------------------
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    assign w_a_neg = bus.op[0] & bus.srcA[WIDTH-1];
    assign w_b_neg = bus.op[0] & bus.srcB[WIDTH-1];
    // Negating the most negative value yields 2^(WIDTH-1), which is the
    // correct magnitude when read as unsigned.
    assign w_a_mag = w_a_neg ? -bus.srcA : bus.srcA;
    assign w_b_mag = w_b_neg ? -bus.srcB : bus.srcB;

    // ------------------------------------------------------------------
    // One multiply iteration: conditional add into the upper half, then
    // shift the whole product right (multiplier bits drain out of the LSB).
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_b_mag} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // One restoring-divide iteration: shift the next dividend bit into the
    // partial remainder, subtract the divisor if it fits.
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_div_tmp;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_div_tmp  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge   = (w_div_tmp >= {1'b0, r_b_mag});
    // The true difference is below the divisor, so WIDTH bits suffice.
    assign w_div_diff = w_div_tmp[WIDTH-1:0] - r_b_mag;
    assign w_div_next = w_div_ge
                      ? {w_div_diff,          r_acc[WIDTH-2:0], 1'b1}
                      : {w_div_tmp[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    // ------------------------------------------------------------------
    // Sign correction for the write-back cycle
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quot = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (bus.start) w_next = S_RUN;
            S_RUN: begin
                if (bus.flush)           w_next = S_IDLE;
                else if (r_cnt == C_LAST) w_next = S_FIX;
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b_zero  <= 1'b0;
            r_b_mag   <= '0;
            r_a_raw   <= '0;
            r_acc     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_busy <= (w_next != S_IDLE);
            unique case (r_state)
                S_IDLE: begin
                    if (bus.wrHi) r_hi <= bus.wrData;
                    if (bus.wrLo) r_lo <= bus.wrData;
                    if (bus.start) begin
                        r_cnt     <= '0;
                        r_is_div  <= bus.op[1];
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_b_zero  <= (bus.srcB == '0);
                        r_b_mag   <= w_b_mag;
                        r_a_raw   <= bus.srcA;
                        r_acc     <= {{WIDTH{1'b0}}, w_a_mag};
                    end
                end
                S_RUN: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= (bus.flush || r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
                end
                S_FIX: begin
                    // flush wins over completion: registers keep old values
                    if (!bus.flush) begin
                        r_done <= 1'b1;
                        if (!r_is_div) begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end else if (r_b_zero) begin
                            r_hi <= r_a_raw;
                            r_lo <= '1;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire
